// File: rtl/send_board_state_pkg.sv
// Shared types and character constants for the board serialiser.
// SEND_BOARD_CRLF_EN selects a CR+LF row terminator instead of LF only.
package send_board_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } send_state_t;

    localparam logic [7:0] CH_A        = 8'h4F;
    localparam logic [7:0] CH_B        = 8'h58;
    localparam logic [7:0] CH_EMPTY    = 8'h2E;
    localparam logic [7:0] CH_CONFLICT = 8'h3F;
    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_LF       = 8'h0A;

`ifdef SEND_BOARD_CRLF_EN
    localparam int TERM_LEN = 2;
`else
    localparam int TERM_LEN = 1;
`endif

endpackage

// File: rtl/send_board_state_if.sv
// Request/board/UART handshake bundle between the game controller, the
// serialiser and the UART transmitter.
interface send_board_state_if #(
    parameter int ROWS = 3,
    parameter int COLS = 3
);
    logic                   req;
    logic [ROWS*COLS-1:0]   board_a;
    logic [ROWS*COLS-1:0]   board_b;
    logic                   ready;
    logic                   valid;
    logic                   uart_wr;
    logic [7:0]             uart_d;
    logic                   uart_ready;

    modport master (
        output req, board_a, board_b, uart_ready,
        input  ready, valid, uart_wr, uart_d
    );

    modport slave (
        input  req, board_a, board_b, uart_ready,
        output ready, valid, uart_wr, uart_d
    );
endinterface

// File: rtl/send_board_state_encoder.sv
// Maps one cell's occupancy bits to its ASCII character.
module board_cell_encoder
    import send_board_pkg::*;
(
    input  logic       cell_a,
    input  logic       cell_b,
    output logic [7:0] cell_char
);

    // Occupancy pair to character
    always_comb begin
        cell_char = CH_EMPTY;
        case ({cell_a, cell_b})
            2'b10:   cell_char = CH_A;
            2'b01:   cell_char = CH_B;
            2'b11:   cell_char = CH_CONFLICT;
            default: cell_char = CH_EMPTY;
        endcase
    end

endmodule

// File: rtl/send_board_state.sv
// Sends a latched tic-tac-toe board over the UART, one byte per cell, row by
// row; SEND_BOARD_CRLF_EN chooses CR+LF rather than LF as row terminator.
module send_board_state
    import send_board_pkg::*;
#(
    parameter int ROWS = 3,
    parameter int COLS = 3
) (
    input  logic               clk,
    input  logic               reset,
    send_board_state_if.slave  bus
);

    localparam int CELLS = ROWS * COLS;
    localparam int COL_W = $clog2(COLS + 2);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

    localparam logic [COL_W-1:0] TERM_COL = COL_W'(COLS);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS + TERM_LEN - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    send_state_t        state_r;
    logic [CELLS-1:0]   board_a_r;
    logic [CELLS-1:0]   board_b_r;
    logic [COL_W-1:0]   col_r;
    logic [ROW_W-1:0]   row_r;
    logic               last_r;
    logic               ready_r;
    logic               valid_r;
    logic               uart_wr_r;
    logic [7:0]         uart_d_r;

    logic [IDX_W-1:0]   idx_s;
    logic               cell_a_s;
    logic               cell_b_s;
    logic [7:0]         cell_char_s;
    logic [7:0]         byte_s;
    logic               is_last_s;

    // Select the cell addressed by the row/column counters
    always_comb begin
        idx_s    = IDX_W'(row_r) * IDX_W'(COLS) + IDX_W'(col_r);
        cell_a_s = board_a_r[idx_s];
        cell_b_s = board_b_r[idx_s];
    end

    board_cell_encoder u_enc (
        .cell_a    (cell_a_s),
        .cell_b    (cell_b_s),
        .cell_char (cell_char_s)
    );

    // Cell character or terminator, depending on column position
    always_comb begin
        byte_s    = cell_char_s;
        is_last_s = (row_r == LAST_ROW) && (col_r == LAST_COL);
        if (col_r < TERM_COL) begin
            byte_s = cell_char_s;
        end else if (col_r == LAST_COL) begin
            byte_s = CH_LF;
        end else begin
            byte_s = CH_CR;
        end
    end

    // Frame sequencer with registered handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            board_a_r <= '0;
            board_b_r <= '0;
            col_r     <= '0;
            row_r     <= '0;
            last_r    <= 1'b0;
            ready_r   <= 1'b1;
            valid_r   <= 1'b0;
            uart_wr_r <= 1'b0;
            uart_d_r  <= 8'h00;
        end else begin
            uart_wr_r <= 1'b0;
            valid_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.req) begin
                        board_a_r <= bus.board_a;
                        board_b_r <= bus.board_b;
                        col_r     <= '0;
                        row_r     <= '0;
                        last_r    <= 1'b0;
                        ready_r   <= 1'b0;
                        state_r   <= ST_EMIT;
                    end else begin
                        ready_r   <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (bus.uart_ready) begin
                        uart_wr_r <= 1'b1;
                        uart_d_r  <= byte_s;
                        last_r    <= is_last_s;
                        state_r   <= ST_GAP;
                        if (col_r == LAST_COL) begin
                            col_r <= '0;
                            row_r <= (row_r == LAST_ROW) ? '0 : row_r + ROW_W'(1);
                        end else begin
                            col_r <= col_r + COL_W'(1);
                        end
                    end else begin
                        state_r <= ST_EMIT;
                    end
                end
                ST_GAP: begin
                    if (last_r) begin
                        valid_r <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_EMIT;
                    end
                end
                ST_DONE: begin
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready   = ready_r;
    assign bus.valid   = valid_r;
    assign bus.uart_wr = uart_wr_r;
    assign bus.uart_d  = uart_d_r;

endmodule

// File: tb/tb_send_board_state.sv
// Scoreboard bench for send_board_state: expected bytes are queued when a
// request is issued and compared as the DUT strobes uart_wr.
module tb_send_board_state;
    import send_board_pkg::*;

    localparam int ROWS = 3;
    localparam int COLS = 3;
`ifdef SEND_BOARD_CRLF_EN
    localparam int NB = ROWS * (COLS + 2);
`else
    localparam int NB = ROWS * (COLS + 1);
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    send_board_state_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    send_board_state #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_char(input logic a, input logic b);
        if (a && b)  return 8'h3F;
        else if (a)  return 8'h4F;
        else if (b)  return 8'h58;
        else         return 8'h2E;
    endfunction

    task automatic push_frame(input logic [8:0] a, input logic [8:0] b);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                exp_q.push_back(model_char(a[r*COLS+c], b[r*COLS+c]));
            end
`ifdef SEND_BOARD_CRLF_EN
            exp_q.push_back(8'h0D);
`endif
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            check_val("late_valid", {31'd0, bus.valid}, 32'd0);
            check_val("late_wr", {31'd0, bus.uart_wr}, 32'd0);
        end
    endtask

    task automatic run_frame(input logic [8:0] a, input logic [8:0] b,
                             input int stall_len, input int repulse_byte,
                             input int reset_after);
        int bytes = 0;
        int valids = 0;
        int cyc = 0;
        int stalled = 0;
        int valid_cyc = -1;
        bit repulsed = 1'b0;
        bit done = 1'b0;
        bit was_reset = 1'b0;

        bus.board_a = a;
        bus.board_b = b;
        bus.req     = 1'b1;
        push_frame(a, b);
        tick();
        bus.req = 1'b0;
        check_val("ready_low", {31'd0, bus.ready}, 32'd0);

        while (!done && cyc < 400) begin
            bus.uart_ready = 1'b1;
            if (stall_len > 0 && bytes >= 4 && stalled < stall_len) begin
                bus.uart_ready = 1'b0;
                stalled++;
            end
            if (bytes == repulse_byte && !repulsed) begin
                bus.req     = 1'b1;
                bus.board_a = ~a;
                bus.board_b = a;
                repulsed    = 1'b1;
            end
            tick();
            cyc++;
            bus.req = 1'b0;
            if (!bus.uart_ready) check_val("stall_wr", {31'd0, bus.uart_wr}, 32'd0);
            if (bus.uart_wr) begin
                bytes++;
                if (exp_q.size() == 0) check_val("byte_count", bytes, NB);
                else check_val($sformatf("byte%0d", bytes), {24'd0, bus.uart_d}, {24'd0, exp_q.pop_front()});
            end
            if (bus.valid) begin
                valids++;
                valid_cyc = cyc;
                check_val("ready_done", {31'd0, bus.ready}, 32'd0);
                tick();
                check_val("ready_back", {31'd0, bus.ready}, 32'd1);
                check_val("valid_pulse", {31'd0, bus.valid}, 32'd0);
                done = 1'b1;
            end
            if (reset_after > 0 && bytes == reset_after && !done) begin
                reset = 1'b1;
                #1;
                check_val("rst_wr", {31'd0, bus.uart_wr}, 32'd0);
                check_val("rst_ready", {31'd0, bus.ready}, 32'd1);
                check_val("rst_valid", {31'd0, bus.valid}, 32'd0);
                tick();
                tick();
                reset = 1'b0;
                exp_q.delete();
                was_reset = 1'b1;
                done = 1'b1;
            end
        end

        bus.uart_ready = 1'b1;
        if (!done) check_val("timeout", cyc, 32'd0);
        if (was_reset) begin
            quiet_check(2 * NB);
        end else begin
            check_val("byte_total", bytes, NB);
            check_val("valid_count", valids, 32'd1);
            check_val("q_left", exp_q.size(), 32'd0);
            if (stall_len == 0) check_val("valid_time", valid_cyc, 2 * NB);
            if (repulse_byte >= 0) quiet_check(2 * NB);
        end
    endtask

    initial begin
        bus.req        = 1'b0;
        bus.board_a    = '0;
        bus.board_b    = '0;
        bus.uart_ready = 1'b1;
        reset          = 1'b1;
        tick();
        tick();
        check_val("rst_ready0", {31'd0, bus.ready}, 32'd1);
        check_val("rst_valid0", {31'd0, bus.valid}, 32'd0);
        check_val("rst_wr0", {31'd0, bus.uart_wr}, 32'd0);
        check_val("rst_d0", {24'd0, bus.uart_d}, 32'd0);
        reset = 1'b0;
        tick();

        run_frame(9'b000000000, 9'b000000000, 0, -1, 0);
        run_frame(9'b000000001, 9'b000001000, 0, -1, 0);
        run_frame(9'b100000000, 9'b100000000, 0, -1, 0);
        run_frame(9'h0AA, 9'h111, 20, -1, 0);
        run_frame(9'h054, 9'h0A3, 0, 3, 0);
        run_frame(9'h003, 9'h1C0, 0, -1, 7);
        run_frame(9'h003, 9'h1C0, 0, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
